scratchpad_tdp_arbiter: RTL and testbench

Shares the two ports of one true dual-port block-RAM scratchpad (common clock, read-first, fixed read latency) among `NUM_REQ` requesters. Each cycle it grants up to two requests, one per RAM port, using round-robin, and drives the RAM port pins directly. It returns read data to the originating requester after the RAM read latency. It sits between the scratchpad clients (load/store engines, compute-side readers) and the BRAM wrapper.

---
 rtl/scratchpad_pkg.sv | 27 ++
 rtl/scratchpad_tdp_arbiter_rr_find_first.sv | 29 ++
 rtl/scratchpad_tdp_arbiter.sv | 165 ++++++++++++++++
 tb/tb_scratchpad_tdp_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scratchpad_pkg.sv
// Shared types and helpers for the scratchpad dual-port arbiter.
// Contents: requester id width helper, read-tracking entry type, latency bound.
package scratchpad_pkg;

    // Largest RAM read latency the tracking pipeline is built for
    localparam int unsigned MAX_READ_LATENCY = 3;

    // Id field is sized for the largest supported requester count (8)
    localparam int unsigned MAX_REQ_ID_W = 3;

    // Bits needed to index n requesters (at least 1)
    function automatic int unsigned REQ_ID_W(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    // One stage of the per-port read tracking pipeline
    typedef struct packed {
        logic                    valid;
        logic [MAX_REQ_ID_W-1:0] id;
    } track_entry_t;

endpackage

// File: rtl/scratchpad_tdp_arbiter_rr_find_first.sv
// Rotating find-first-set: lowest set bit of req at or above base, wrapping.
// Ports: req (candidate vector), base (start index), found_c/idx_c (result).
module rr_find_first #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] base,
    output logic             found_c,
    output logic [IDX_W-1:0] idx_c
);

    logic [IDX_W-1:0] cand;

    // Scan offsets high to low so the smallest offset from base wins
    always_comb begin
        found_c = 1'b0;
        idx_c   = '0;
        cand    = '0;
        for (int off = int'(N) - 1; off >= 0; off--) begin
            cand = IDX_W'((32'(base) + 32'(off)) % N);
            if (req[cand]) begin
                found_c = 1'b1;
                idx_c   = cand;
            end
        end
    end

endmodule

// File: rtl/scratchpad_tdp_arbiter.sv
// Round-robin arbiter sharing both ports of a true dual-port scratchpad RAM.
// Ports: req_* (per-requester request bus), rsp_* (read data return),
//        mem_* (RAM port A/B pins, driven directly each cycle).
module scratchpad_tdp_arbiter
    import scratchpad_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]  rsp_data,
    output logic                           mem_ena,
    output logic                           mem_wea,
    output logic [ADDR_WIDTH-1:0]          mem_addra,
    output logic [DATA_WIDTH-1:0]          mem_dina,
    input  logic [DATA_WIDTH-1:0]          mem_douta,
    output logic                           mem_enb,
    output logic                           mem_web,
    output logic [ADDR_WIDTH-1:0]          mem_addrb,
    output logic [DATA_WIDTH-1:0]          mem_dinb,
    input  logic [DATA_WIDTH-1:0]          mem_doutb,
    output logic                           mem_regcea,
    output logic                           mem_regceb
);

    localparam int unsigned IDX_W = REQ_ID_W(NUM_REQ);

    // Successor index modulo NUM_REQ
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return IDX_W'((32'(i) + 32'd1) % NUM_REQ);
    endfunction

    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic                  a_found, b_found;
    logic [IDX_W-1:0]      a_idx, b_idx, b_base;
    logic [NUM_REQ-1:0]    b_mask;
    logic                  a_we, b_we;
    logic [ADDR_WIDTH-1:0] a_addr, b_addr;
    logic [DATA_WIDTH-1:0] a_wdata, b_wdata;
    logic                  conflict;
    logic                  grant_a, grant_b;

    track_entry_t track_a_q [READ_LATENCY];
    track_entry_t track_a_d [READ_LATENCY];
    track_entry_t track_b_q [READ_LATENCY];
    track_entry_t track_b_d [READ_LATENCY];
    track_entry_t last_a, last_b;

    // Port A: first valid requester from the round-robin pointer
    rr_find_first #(.N(NUM_REQ), .IDX_W(IDX_W)) u_find_a (
        .req     (req_valid),
        .base    (ptr_q),
        .found_c (a_found),
        .idx_c   (a_idx)
    );

    assign b_mask = req_valid & ~(NUM_REQ'(1) << a_idx);
    assign b_base = next_idx(a_idx);

    // Port B: next valid requester after A, A itself masked out
    rr_find_first #(.N(NUM_REQ), .IDX_W(IDX_W)) u_find_b (
        .req     (b_mask),
        .base    (b_base),
        .found_c (b_found),
        .idx_c   (b_idx)
    );

    assign a_we    = req_we[a_idx];
    assign b_we    = req_we[b_idx];
    assign a_addr  = req_addr[a_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign b_addr  = req_addr[b_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign a_wdata = req_wdata[a_idx*DATA_WIDTH +: DATA_WIDTH];
    assign b_wdata = req_wdata[b_idx*DATA_WIDTH +: DATA_WIDTH];

    // Same-address access involving a write would race across ports; B retries
    assign conflict = (a_addr == b_addr) && (a_we || b_we);

    assign grant_a = a_found && !rst;
    assign grant_b = b_found && !conflict && !rst;

    // Grants, RAM pins and pointer advance
    always_comb begin
        req_ready = '0;
        mem_ena   = 1'b0;
        mem_wea   = 1'b0;
        mem_addra = '0;
        mem_dina  = '0;
        mem_enb   = 1'b0;
        mem_web   = 1'b0;
        mem_addrb = '0;
        mem_dinb  = '0;
        ptr_d     = ptr_q;
        if (grant_a) begin
            req_ready[a_idx] = 1'b1;
            mem_ena          = 1'b1;
            mem_wea          = a_we;
            mem_addra        = a_addr;
            mem_dina         = a_wdata;
            ptr_d            = next_idx(a_idx);
        end
        if (grant_b) begin
            req_ready[b_idx] = 1'b1;
            mem_enb          = 1'b1;
            mem_web          = b_we;
            mem_addrb        = b_addr;
            mem_dinb         = b_wdata;
            ptr_d            = next_idx(b_idx);
        end
    end

    assign mem_regcea = 1'b1;
    assign mem_regceb = 1'b1;

    // Read tracking: stage 0 loads this cycle's grant, later stages shift
    always_comb begin
        track_a_d[0] = '{valid: grant_a && !a_we, id: MAX_REQ_ID_W'(a_idx)};
        track_b_d[0] = '{valid: grant_b && !b_we, id: MAX_REQ_ID_W'(b_idx)};
        for (int s = 1; s < int'(READ_LATENCY); s++) begin
            track_a_d[s] = track_a_q[s-1];
            track_b_d[s] = track_b_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            for (int s = 0; s < int'(READ_LATENCY); s++) begin
                track_a_q[s] <= '0;
                track_b_q[s] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            track_a_q <= track_a_d;
            track_b_q <= track_b_d;
        end
    end

    assign last_a = track_a_q[READ_LATENCY-1];
    assign last_b = track_b_q[READ_LATENCY-1];

    // Response demux: a requester is granted at most once per cycle, so ports never collide
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!rst && last_a.valid && (last_a.id == MAX_REQ_ID_W'(i))) begin
                rsp_valid[i]                       = 1'b1;
                rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_douta;
            end else if (!rst && last_b.valid && (last_b.id == MAX_REQ_ID_W'(i))) begin
                rsp_valid[i]                       = 1'b1;
                rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_doutb;
            end
        end
    end

endmodule

// File: tb/tb_scratchpad_tdp_arbiter.sv
// Bench for scratchpad_tdp_arbiter: directed scenarios plus random traffic,
// checked against a rotation-order grant model and a golden memory image.
module tb_scratchpad_tdp_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int RL = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_ready, req_we, rsp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata, rsp_data;
    logic              mem_ena, mem_wea, mem_enb, mem_web, mem_regcea, mem_regceb;
    logic [AW-1:0]     mem_addra, mem_addrb;
    logic [DW-1:0]     mem_dina, mem_dinb, mem_douta, mem_doutb;

    logic [AW-1:0]     t_addr  [NR];
    logic [DW-1:0]     t_wdata [NR];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = t_addr[i];
            req_wdata[i*DW +: DW] = t_wdata[i];
        end
    end

    scratchpad_tdp_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra),
        .mem_dina(mem_dina), .mem_douta(mem_douta),
        .mem_enb(mem_enb), .mem_web(mem_web), .mem_addrb(mem_addrb),
        .mem_dinb(mem_dinb), .mem_doutb(mem_doutb),
        .mem_regcea(mem_regcea), .mem_regceb(mem_regceb)
    );

    // Read-first true dual-port RAM with RL-cycle output latency
    logic [DW-1:0] ram      [256];
    logic [DW-1:0] init_mem [256];
    logic          load_ram;
    logic [DW-1:0] pa [RL];
    logic [DW-1:0] pb [RL];

    always @(posedge clk) begin
        if (load_ram) begin
            for (int a = 0; a < 256; a++) ram[a] <= init_mem[a];
        end else begin
            if (mem_ena) begin
                pa[0] <= ram[mem_addra];
                if (mem_wea) ram[mem_addra] <= mem_dina;
            end
            if (mem_enb) begin
                pb[0] <= ram[mem_addrb];
                if (mem_web) ram[mem_addrb] <= mem_dinb;
            end
        end
        for (int s = 1; s < RL; s++) begin
            pa[s] <= pa[s-1];
            pb[s] <= pb[s-1];
        end
    end

    assign mem_douta = pa[RL-1];
    assign mem_doutb = pb[RL-1];

    // Reference model state
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] gold [256];
    int            mptr  = 0;
    int            cyc   = 0;
    int            tests = 0;
    int            fails = 0;

    logic [NR-1:0]    last_ready, last_rsp_valid;
    logic [NR*DW-1:0] last_rsp_data;
    logic [AW-1:0]    last_addra, last_addrb;

    task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        req_valid = '0;
        req_we    = '0;
        for (int i = 0; i < NR; i++) begin
            t_addr[i]  = '0;
            t_wdata[i] = '0;
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        t_addr[i]    = addr;
        t_wdata[i]   = wd;
    endtask

    // One clock cycle: check outputs mid-cycle against the model, then advance the model
    task automatic step();
        int               ga, gb;
        logic [NR-1:0]    er, ev;
        logic [NR*DW-1:0] ed;
        logic             ea, eb, ewa, ewb;
        logic [AW-1:0]    eaa, eab;
        logic [DW-1:0]    eda, edb;
        @(negedge clk);
        ga = -1;
        gb = -1;
        if (!rst) begin
            // Grants are the first two valid requesters in rotation order from the pointer
            for (int k = 0; k < NR; k++) begin
                if (req_valid[(mptr + k) % NR]) begin
                    if (ga < 0)      ga = (mptr + k) % NR;
                    else if (gb < 0) gb = (mptr + k) % NR;
                end
            end
            if (ga >= 0 && gb >= 0 && t_addr[ga] == t_addr[gb] && (req_we[ga] || req_we[gb]))
                gb = -1;
        end
        er = '0; ea = 0; ewa = 0; eaa = '0; eda = '0;
        eb = 0; ewb = 0; eab = '0; edb = '0;
        if (ga >= 0) begin
            er[ga] = 1'b1; ea = 1; ewa = req_we[ga]; eaa = t_addr[ga]; eda = t_wdata[ga];
        end
        if (gb >= 0) begin
            er[gb] = 1'b1; eb = 1; ewb = req_we[gb]; eab = t_addr[gb]; edb = t_wdata[gb];
        end
        ev = '0;
        ed = '0;
        if (!rst) begin
            foreach (q[k]) begin
                if (q[k].due == cyc) begin
                    ev[q[k].id]            = 1'b1;
                    ed[q[k].id*DW +: DW]   = q[k].data;
                end
            end
        end
        chk("req_ready", req_ready, er);
        chk("mem_ena",   mem_ena, ea);
        chk("mem_wea",   mem_wea, ewa);
        chk("mem_addra", mem_addra, eaa);
        chk("mem_dina",  mem_dina, eda);
        chk("mem_enb",   mem_enb, eb);
        chk("mem_web",   mem_web, ewb);
        chk("mem_addrb", mem_addrb, eab);
        chk("mem_dinb",  mem_dinb, edb);
        chk("rsp_valid", rsp_valid, ev);
        chk("rsp_data",  rsp_data, ed);
        last_ready     = req_ready;
        last_rsp_valid = rsp_valid;
        last_rsp_data  = rsp_data;
        last_addra     = mem_addra;
        last_addrb     = mem_addrb;
        @(posedge clk);
        if (rst) begin
            mptr = 0;
            q.delete();
        end else begin
            if (ga >= 0 && !req_we[ga]) q.push_back('{due: cyc + RL, id: ga, data: gold[t_addr[ga]]});
            if (gb >= 0 && !req_we[gb]) q.push_back('{due: cyc + RL, id: gb, data: gold[t_addr[gb]]});
            if (ga >= 0 && req_we[ga]) gold[t_addr[ga]] = t_wdata[ga];
            if (gb >= 0 && req_we[gb]) gold[t_addr[gb]] = t_wdata[gb];
            if (gb >= 0)      mptr = (gb + 1) % NR;
            else if (ga >= 0) mptr = (ga + 1) % NR;
        end
        for (int k = q.size() - 1; k >= 0; k--) begin
            if (q[k].due <= cyc) q.delete(k);
        end
        cyc++;
        #1;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) gold[a] = $urandom;
        gold[8'h10] = 32'hDEADBEEF;
        gold[8'h20] = 32'h12345678;
        for (int a = 0; a < 256; a++) init_mem[a] = gold[a];
        load_ram = 1'b1;
        rst      = 1'b1;
        set_idle();
        req_valid = '1;

        // Reset: no grants, no enables, no responses even with all requesters valid
        step();
        load_ram = 1'b0;
        step();
        chk("rst_ready", last_ready, '0);
        chk("regce", {mem_regcea, mem_regceb}, 2'b11);

        // Single reader: requester 2 reads 0x10
        rst = 1'b0;
        set_idle();
        set_req(2, 1'b0, 8'h10, '0);
        step();
        chk("single_ready", last_ready, 4'b0100);
        set_idle();
        step();
        step();
        chk("single_rsp_valid", last_rsp_valid, 4'b0100);
        chk("single_rsp_data", last_rsp_data[2*DW +: DW], 32'hDEADBEEF);

        // Bring pointer to 0 (last grant 3), then all four valid
        set_req(3, 1'b0, 8'h30, '0);
        step();
        set_idle();
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 8'(8'h40 + i), '0);
        step();
        chk("rr_c0_ready", last_ready, 4'b0011);
        chk("rr_c0_addr", {last_addra, last_addrb}, 16'h4041);
        step();
        chk("rr_c1_ready", last_ready, 4'b1100);
        chk("rr_c1_addr", {last_addra, last_addrb}, 16'h4243);
        step();
        chk("rr_c2_ready", last_ready, 4'b0011);
        step();
        set_idle();
        step();
        step();

        // Conflict: write and read to address 7 in the same cycle
        set_req(0, 1'b1, 8'h07, 32'h5A);
        set_req(1, 1'b0, 8'h07, '0);
        step();
        chk("conflict_ready", last_ready, 4'b0001);
        req_valid[0] = 1'b0;
        req_we[0]    = 1'b0;
        step();
        chk("retry_ready", last_ready, 4'b0010);
        set_idle();
        step();
        step();
        chk("retry_rsp_valid", last_rsp_valid, 4'b0010);
        chk("retry_rsp_data", last_rsp_data[1*DW +: DW], 32'h5A);

        // Dual read of the same address
        set_req(1, 1'b0, 8'h20, '0);
        set_req(3, 1'b0, 8'h20, '0);
        step();
        chk("dual_ready", last_ready, 4'b1010);
        set_idle();
        step();
        step();
        chk("dual_rsp_valid", last_rsp_valid, 4'b1010);
        chk("dual_rsp_data1", last_rsp_data[1*DW +: DW], 32'h12345678);
        chk("dual_rsp_data3", last_rsp_data[3*DW +: DW], 32'h12345678);

        // Reset one cycle after a read is accepted
        set_req(2, 1'b0, 8'h10, '0);
        step();
        chk("flight_ready", last_ready, 4'b0100);
        set_idle();
        rst = 1'b1;
        step();
        chk("flight_rsp_rst", last_rsp_valid, 4'b0000);
        rst = 1'b0;
        for (int i = 1; i < NR; i++) set_req(i, 1'b0, 8'(8'h40 + i), '0);
        step();
        chk("post_rst_ready", last_ready, 4'b0110);
        chk("post_rst_rsp", last_rsp_valid, 4'b0000);
        set_idle();
        step();
        step();

        // Random traffic on a small address window to provoke conflicts
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            req_valid = NR'($urandom);
            for (int i = 0; i < NR; i++) begin
                req_we[i]  = ($urandom_range(0, 2) == 0);
                t_addr[i]  = 8'($urandom_range(0, 7));
                t_wdata[i] = $urandom;
            end
            step();
        end
        rst = 1'b0;
        set_idle();
        for (int n = 0; n < RL + 1; n++) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
